// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/fa_cell.sv
// Single-bit full adder; the only arithmetic element of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of one bit position.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | ((a ^ b) & ci);
  end

endmodule : fa_cell

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: {cout,sum} = x + y + cin, one bit per clock.
// Operands are loaded in parallel, walked through one full-adder cell, and
// the result is presented in parallel with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // cnt only ever reaches WIDTH-1, so clog2(WIDTH) bits are enough.
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;

  fa_cell u_fa (
    .a  (xs[0]),
    .b  (ys[0]),
    .ci (c),
    .s  (fa_s),
    .co (fa_co)
  );

  // Control FSM and datapath: load, shift one bit per RUN cycle, publish result.
  // NOTE: every state register here uses <= so all of them update from the
  // same pre-edge values; a blocking = would let later lines see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift registers are plain flops, not a memory array, so
      // clearing them in reset costs nothing and keeps state deterministic.
      state <= IDLE;
      xs    <= '0;
      ys    <= '0;
      acc   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new start exactly like IDLE, allowing back-to-back ops.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            xs    <= x;
            ys    <= y;
            c     <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          // New bit enters at the MSB; after WIDTH shifts bit i sits at index i.
          acc <= {fa_s, acc[WIDTH-1:1]};
          xs  <= xs >> 1;
          ys  <= ys >> 1;
          c   <= fa_co;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            sum   <= {fa_s, acc[WIDTH-1:1]};
            cout  <= fa_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, asynchronous abort,
// and randomized back-to-back / gapped operations against x + y + cin.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks;
  int n_fail;

  // Last result the DUT should be holding on sum/cout.
  logic [W:0] last_exp;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One full operation. Called just after a negedge; returns at the negedge
  // of the DONE cycle with start low, so a following op() is back-to-back.
  // noisy=1 toggles start/x/y/cin at random while the adder is running.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                    input bit noisy);
    logic [W:0] exp;
    exp   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    x     = a;
    y     = b;
    cin   = ci;
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (noisy) begin
        start = 1'($urandom);
        x     = W'($urandom);
        y     = W'($urandom);
        cin   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      check("busy_run", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("sum", 32'(sum), 32'(exp[W-1:0]));
    check("cout", 32'(cout), 32'(exp[W]));
    last_exp = exp;
  endtask

  // Idle cycles with start low: no done, not busy, result held.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("done_idle", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("sum_hold", 32'(sum), 32'(last_exp[W-1:0]));
      check("cout_hold", 32'(cout), 32'(last_exp[W]));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    start    = 1'b0;
    x        = '0;
    y        = '0;
    cin      = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Directed cases.
    op(8'h5A, 8'h33, 1'b0, 1'b0);
    check("sum_5a_33", 32'(sum), 32'h8D);
    idle(2);
    op(8'hFF, 8'h01, 1'b0, 1'b0);
    check("cout_ff_01", 32'(cout), 32'd1);
    op(8'hFF, 8'hFF, 1'b1, 1'b0);
    check("sum_ff_ff_1", 32'(sum), 32'hFF);
    idle(1);

    // Start and operand changes while running are ignored; then back-to-back.
    op(8'h5A, 8'h33, 1'b0, 1'b1);
    op(8'h01, 8'h01, 1'b0, 1'b0);
    check("sum_01_01", 32'(sum), 32'h02);
    idle(1);

    // Asynchronous reset in the middle of RUN.
    x     = 8'hC3;
    y     = 8'h7E;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_exp = '0;
    idle(2 * W);

    // Randomized operations, mixing back-to-back and idle gaps.
    for (int n = 0; n < 1000; n++) begin
      int gap;
      op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
      gap = (n[0]) ? 0 : int'($urandom_range(0, 3));
      if (gap > 0) idle(gap);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_adder
